// File: rtl/nor_gate_exerciser_pkg.sv
// Shared definitions for the 2-input gate exerciser: FSM state encoding and
// the expected-function codes selectable through the FUNC parameter.
package nor_gate_exerciser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int unsigned FUNC_NOR  = 0;
   localparam int unsigned FUNC_NAND = 1;
   localparam int unsigned FUNC_AND  = 2;
   localparam int unsigned FUNC_OR   = 3;
   localparam int unsigned FUNC_XOR  = 4;
   localparam int unsigned FUNC_XNOR = 5;

endpackage

// File: rtl/nor_gate_exerciser_gate_ref_model.sv
// Combinational golden model of a 2-input cell; FUNC selects the boolean function.
// Unknown codes fall back to NOR.
module nor_gate_exerciser_gate_ref_model
   import nor_gate_exerciser_pkg::*;
#(
   parameter int unsigned FUNC = FUNC_NOR
) (
   input  logic in1_i,
   input  logic in2_i,
   output logic expected_o
);

   always_comb begin
      case (FUNC)
         FUNC_NAND: expected_o = ~(in1_i & in2_i);
         FUNC_AND:  expected_o = in1_i & in2_i;
         FUNC_OR:   expected_o = in1_i | in2_i;
         FUNC_XOR:  expected_o = in1_i ^ in2_i;
         FUNC_XNOR: expected_o = ~(in1_i ^ in2_i);
         default:   expected_o = ~(in1_i | in2_i);
      endcase
   end

endmodule

// File: rtl/nor_gate_exerciser.sv
// Drives all four input vectors into a 2-input gate under test, waits a settle time,
// samples its output against the reference function and keeps a run scoreboard.
module nor_gate_exerciser
   import nor_gate_exerciser_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned PASSES        = 1,
   parameter int unsigned FUNC          = FUNC_NOR,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_y,
   output logic             drive_in1,
   output logic             drive_in2,
   output logic             busy,
   output logic             done,
   output logic             pass_ok,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_vld,
   output logic [1:0]       first_fail_vec,
   output state_e           dbg_state_o
);

   localparam int unsigned       PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int unsigned       SET_W     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
   localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES);

   state_e            state_q, state_d;
   logic [1:0]        vec_q, vec_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              ff_vld_q, ff_vld_d;
   logic [1:0]        ff_vec_q, ff_vec_d;
   logic              exp_y;
   logic              mismatch;

   nor_gate_exerciser_gate_ref_model #(.FUNC(FUNC)) u_ref (
      .in1_i      (vec_q[1]),
      .in2_i      (vec_q[0]),
      .expected_o (exp_y)
   );

   // Case inequality so a floating or unknown gate output is scored as a failure.
   assign mismatch = (dut_y !== exp_y);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         pass_q   <= '0;
         settle_q <= '0;
         err_q    <= '0;
         ff_vld_q <= 1'b0;
         ff_vec_q <= '0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         pass_q   <= pass_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         ff_vld_q <= ff_vld_d;
         ff_vec_q <= ff_vec_d;
      end
   end

   // start and abort are level-sampled single-cycle requests with no ready:
   // abort always wins, start is only taken in IDLE or DONE and dropped otherwise.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      pass_d   = pass_q;
      settle_d = settle_q;
      err_d    = err_q;
      ff_vld_d = ff_vld_q;
      ff_vec_d = ff_vec_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d  = ST_DRIVE;
                  vec_d    = '0;
                  pass_d   = '0;
                  err_d    = '0;
                  ff_vld_d = 1'b0;
                  ff_vec_d = '0;
               end
            end
            ST_DRIVE: begin
               settle_d = SET_LOAD;
               state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_q <= SET_W'(1)) state_d = ST_SAMPLE;
               else                       settle_d = settle_q - SET_W'(1);
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                  if (!ff_vld_q) begin
                     ff_vld_d = 1'b1;
                     ff_vec_d = vec_q;
                  end
               end
               if (vec_q != 2'd3) begin
                  vec_d   = vec_q + 2'd1;
                  state_d = ST_DRIVE;
               end else if (pass_q != PASS_LAST) begin
                  pass_d  = pass_q + PASS_W'(1);
                  vec_d   = '0;
                  state_d = ST_DRIVE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_DRIVE, ST_SETTLE, ST_SAMPLE: busy = 1'b1;
         ST_DONE:                        done = 1'b1;
         default:                        ;
      endcase
   end

   // vec_q only advances on leaving SAMPLE, so the pins hold from DRIVE through SAMPLE.
   assign drive_in1      = busy & vec_q[1];
   assign drive_in2      = busy & vec_q[0];
   assign pass_ok        = done & (err_q == '0);
   assign err_count      = err_q;
   assign first_fail_vld = ff_vld_q;
   assign first_fail_vec = ff_vec_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_nor_gate_exerciser.sv
// Bench for nor_gate_exerciser: three instances (default NOR, 300-pass saturation,
// zero-settle XOR) each wired to a small behavioural gate model.
module tb_nor_gate_exerciser;
   import nor_gate_exerciser_pkg::*;

   logic clk;
   logic rst;
   logic start_a, abort_a, start_b, abort_b, start_c, abort_c;
   logic [1:0] mode_a;
   logic mode_c;
   logic y_b, y_c;
   wire  y_a;
   logic d1_a, d2_a, busy_a, done_a, pok_a, ffv_a;
   logic d1_b, d2_b, busy_b, done_b, pok_b, ffv_b;
   logic d1_c, d2_c, busy_c, done_c, pok_c, ffv_c;
   logic [7:0] err_a, err_b, err_c;
   logic [1:0] ffvec_a, ffvec_b, ffvec_c;
   state_e dbg_a, dbg_b, dbg_c;
   logic y01_seen;

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- gate models ----------------
   // mode_a: 0 good NOR, 1 stuck-at-0, 2 NOR that floats on vector 01
   assign y_a = (mode_a == 2'd2 && !d1_a && d2_a) ? 1'bz :
                (mode_a == 2'd1) ? 1'b0 : ~(d1_a | d2_a);
   assign y_b = 1'b0;
   assign y_c = mode_c ? ~(d1_c | d2_c) : (d1_c ^ d2_c);

   always @(posedge clk) if (busy_a && !d1_a && d2_a) y01_seen <= y_a;

   nor_gate_exerciser u_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_y(y_a),
      .drive_in1(d1_a), .drive_in2(d2_a), .busy(busy_a), .done(done_a),
      .pass_ok(pok_a), .err_count(err_a), .first_fail_vld(ffv_a),
      .first_fail_vec(ffvec_a), .dbg_state_o(dbg_a)
   );

   nor_gate_exerciser #(.PASSES(300)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_y(y_b),
      .drive_in1(d1_b), .drive_in2(d2_b), .busy(busy_b), .done(done_b),
      .pass_ok(pok_b), .err_count(err_b), .first_fail_vld(ffv_b),
      .first_fail_vec(ffvec_b), .dbg_state_o(dbg_b)
   );

   nor_gate_exerciser #(.SETTLE_CYCLES(0), .PASSES(2), .FUNC(FUNC_XOR)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .dut_y(y_c),
      .drive_in1(d1_c), .drive_in2(d2_c), .busy(busy_c), .done(done_c),
      .pass_ok(pok_c), .err_count(err_c), .first_fail_vld(ffv_c),
      .first_fail_vec(ffvec_c), .dbg_state_o(dbg_c)
   );

   // ---------------- reference model ----------------
   function automatic logic golden(input int f, input logic a, input logic b);
      case (f)
         1:       return ~(a & b);
         2:       return a & b;
         3:       return a | b;
         4:       return a ^ b;
         5:       return ~(a ^ b);
         default: return ~(a | b);
      endcase
   endfunction

   // kind: 0 NOR, 1 stuck-at-0, 2 NOR floating on 01 (value fval), 3 XOR
   function automatic logic gate_out(input int kind, input logic a, input logic b, input logic fval);
      case (kind)
         0:       return ~(a | b);
         1:       return 1'b0;
         2:       return (!a && b) ? fval : ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   // Packed result {err_count[7:0], first_fail_vld, first_fail_vec, pass_ok}
   function automatic logic [11:0] model_run(input int passes, input int f, input int kind, input logic fval);
      int errs = 0;
      logic vld = 1'b0;
      logic [1:0] fv = 2'b00;
      logic [1:0] vv;
      for (int p = 0; p < passes; p++) begin
         for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (gate_out(kind, vv[1], vv[0], fval) !== golden(f, vv[1], vv[0])) begin
               if (errs < 255) errs++;
               if (!vld) begin
                  vld = 1'b1;
                  fv  = vv;
               end
            end
         end
      end
      return {8'(errs), vld, fv, (errs == 0)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int sel);
      case (sel)
         0:       start_a = 1'b1;
         1:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   function automatic logic pick_done(input int sel);
      case (sel)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic wait_done(input int sel, input int limit, output int n);
      n = 0;
      while (pick_done(sel) !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic score(input string name, input logic [11:0] got);
      logic [11:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard empty, got=%h", name, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", name, got, e);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      start_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, d1_a, d2_a, pok_a, err_a, ffv_a, ffvec_a} !== 16'h0 || dbg_a !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_a got=%h state=%0d exp=0 state=IDLE",
                  {busy_a, done_a, d1_a, d2_a, pok_a, err_a, ffv_a, ffvec_a}, dbg_a);
      end
      checks++;
      if ({busy_b, done_b, d1_b, d2_b, pok_b, err_b, ffv_b, ffvec_b} !== 16'h0 || dbg_b !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_b got=%h exp=0", {busy_b, done_b, d1_b, d2_b, pok_b, err_b, ffv_b, ffvec_b});
      end
      checks++;
      if ({busy_c, done_c, d1_c, d2_c, pok_c, err_c, ffv_c, ffvec_c} !== 16'h0 || dbg_c !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_c got=%h exp=0", {busy_c, done_c, d1_c, d2_c, pok_c, err_c, ffv_c, ffvec_c});
      end
      start_a = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_good_run();
      mode_a = 2'd0;
      exp_q.push_back(model_run(1, 0, 0, 1'b0));
      pulse_start(0);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if ({d1_a, d2_a} !== 2'(k / 4) || busy_a !== 1'b1 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL good_drive cycle=%0d got=%b%b busy=%b exp=%b busy=1",
                     k, d1_a, d2_a, busy_a, 2'(k / 4));
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL good_latency done=%b busy=%b exp done=1 busy=0", done_a, busy_a);
      end
      score("good_run", {err_a, ffv_a, ffvec_a, pok_a});
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_a !== 1'b1 || {d1_a, d2_a} !== 2'b00) begin
         failures++;
         $display("FAIL done_hold done=%b drives=%b%b exp done=1 drives=00", done_a, d1_a, d2_a);
      end
   endtask

   task automatic test_stuck();
      int n;
      mode_a = 2'd1;
      exp_q.push_back(model_run(1, 0, 1, 1'b0));
      pulse_start(0);
      wait_done(0, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL stuck_latency got=%0d exp=16", n);
      end
      score("stuck_run", {err_a, ffv_a, ffvec_a, pok_a});
   endtask

   task automatic test_done_restart();
      int n;
      mode_a = 2'd0;
      exp_q.push_back(model_run(1, 0, 0, 1'b0));
      pulse_start(0);
      checks++;
      if (err_a !== 8'd0 || ffv_a !== 1'b0 || ffvec_a !== 2'b00 || busy_a !== 1'b1 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL restart_clear err=%0d vld=%b vec=%b busy=%b done=%b exp 0 0 00 1 0",
                  err_a, ffv_a, ffvec_a, busy_a, done_a);
      end
      wait_done(0, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL restart_latency got=%0d exp=16", n);
      end
      score("restart_run", {err_a, ffv_a, ffvec_a, pok_a});
   endtask

   task automatic test_float();
      int n;
      mode_a = 2'd2;
      pulse_start(0);
      wait_done(0, 100, n);
      // Expectation depends on how the simulator represents the floating net.
      exp_q.push_back(model_run(1, 0, 2, y01_seen));
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL float_latency got=%0d exp=16", n);
      end
      score("float_run", {err_a, ffv_a, ffvec_a, pok_a});
   endtask

   task automatic test_abort();
      int n;
      mode_a = 2'd1;
      pulse_start(0);
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (dbg_a !== ST_SETTLE || {d1_a, d2_a} !== 2'b10) begin
         failures++;
         $display("FAIL abort_setup state=%0d drives=%b%b exp state=SETTLE drives=10", dbg_a, d1_a, d2_a);
      end
      abort_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      start_a = 1'b0;
      checks++;
      if (dbg_a !== ST_IDLE || busy_a !== 1'b0 || done_a !== 1'b0 || {d1_a, d2_a} !== 2'b00) begin
         failures++;
         $display("FAIL abort_idle state=%0d busy=%b done=%b drives=%b%b exp IDLE 0 0 00",
                  dbg_a, busy_a, done_a, d1_a, d2_a);
      end
      checks++;
      if (err_a !== 8'd1 || ffv_a !== 1'b1 || ffvec_a !== 2'b00) begin
         failures++;
         $display("FAIL abort_hold err=%0d vld=%b vec=%b exp 1 1 00", err_a, ffv_a, ffvec_a);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dbg_a !== ST_IDLE) begin
         failures++;
         $display("FAIL abort_stays_idle state=%0d exp=IDLE", dbg_a);
      end
      mode_a = 2'd0;
      exp_q.push_back(model_run(1, 0, 0, 1'b0));
      pulse_start(0);
      wait_done(0, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL abort_rerun_latency got=%0d exp=16", n);
      end
      score("abort_rerun", {err_a, ffv_a, ffvec_a, pok_a});
   endtask

   task automatic test_busy_start();
      int n;
      mode_a = 2'd1;
      exp_q.push_back(model_run(1, 0, 1, 1'b0));
      pulse_start(0);
      repeat (5) @(posedge clk);
      #1;
      pulse_start(0);
      wait_done(0, 100, n);
      checks++;
      if (n + 6 != 16) begin
         failures++;
         $display("FAIL busy_start_latency got=%0d exp=16", n + 6);
      end
      score("busy_start_run", {err_a, ffv_a, ffvec_a, pok_a});
   endtask

   task automatic test_rst_mid();
      mode_a = 2'd1;
      pulse_start(0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dbg_a !== ST_SAMPLE) begin
         failures++;
         $display("FAIL rst_mid_setup state=%0d exp=SAMPLE", dbg_a);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy_a, done_a, d1_a, d2_a, pok_a, err_a, ffv_a, ffvec_a} !== 16'h0 || dbg_a !== ST_IDLE) begin
         failures++;
         $display("FAIL rst_mid got=%h state=%0d exp=0 state=IDLE",
                  {busy_a, done_a, d1_a, d2_a, pok_a, err_a, ffv_a, ffvec_a}, dbg_a);
      end
   endtask

   task automatic test_saturate();
      int n;
      exp_q.push_back(model_run(300, 0, 1, 1'b0));
      pulse_start(1);
      wait_done(1, 6000, n);
      checks++;
      if (n != 4800) begin
         failures++;
         $display("FAIL saturate_latency got=%0d exp=4800", n);
      end
      score("saturate_run", {err_b, ffv_b, ffvec_b, pok_b});
   endtask

   task automatic test_func_xor();
      int n;
      mode_c = 1'b0;
      exp_q.push_back(model_run(2, 4, 3, 1'b0));
      pulse_start(2);
      wait_done(2, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL xor_good_latency got=%0d exp=16", n);
      end
      score("xor_good_run", {err_c, ffv_c, ffvec_c, pok_c});
      mode_c = 1'b1;
      exp_q.push_back(model_run(2, 4, 0, 1'b0));
      pulse_start(2);
      wait_done(2, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL xor_bad_latency got=%0d exp=16", n);
      end
      score("xor_bad_run", {err_c, ffv_c, ffvec_c, pok_c});
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0;
      start_c = 1'b0; abort_c = 1'b0;
      mode_a = 2'd0;
      mode_c = 1'b0;
      test_reset();
      test_good_run();
      test_stuck();
      test_done_restart();
      test_float();
      test_abort();
      test_busy_start();
      test_rst_mid();
      test_saturate();
      test_func_xor();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
